// File: rtl/syringe_pkg.sv
// Shared slot-state encoding, default geometry/timing constants and a span-test helper.
package syringe_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_FALLING = 2'd1,
        SLOT_HIT     = 2'd2
    } slot_state_t;

    localparam int NUM_SLOTS_DEF    = 4;
    localparam int SPAWN_PERIOD_DEF = 120;
    localparam int FALL_SPEED_DEF   = 2;
    localparam int OBJ_SIZE_DEF     = 32;
    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int HIT_FRAMES_DEF   = 8;

    // True when base <= p < base+size; widened so base+size cannot wrap.
    function automatic logic in_span(input logic [10:0] p, input logic [10:0] base, input int size);
        logic [11:0] lo;
        lo = {1'b0, base};
        return ({1'b0, p} >= lo) && ({1'b0, p} < lo + 12'(size));
    endfunction

endpackage

// File: rtl/syringe_slot.sv
// One falling syringe: FREE -> FALLING -> (HIT blink countdown | off-screen) -> FREE.
// State, position and hit counter all update on the clock edge; a hit beats motion.
module syringe_slot
    import syringe_pkg::*;
#(
    parameter int OBJ_SIZE   = OBJ_SIZE_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int FALL_SPEED = FALL_SPEED_DEF,
    parameter int HIT_FRAMES = HIT_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame,
    input  logic        spawn,
    input  logic [10:0] spawn_x,
    input  logic        hit,
    output logic [10:0] x,
    output logic [10:0] y,
    output slot_state_t state,
    output logic        drawable,
    output logic        leaving
);

    localparam logic [11:0] Y_LIMIT = 12'(SCREEN_H - OBJ_SIZE);

    logic [3:0]  hit_cnt;
    logic [11:0] y_next;
    logic [3:0]  cnt_dec;

    assign y_next  = {1'b0, y} + 12'(FALL_SPEED);
    assign cnt_dec = hit_cnt - 4'd1;

    // Once the bottom edge reaches the last scan line the object counts as gone.
    assign leaving  = (state == SLOT_FALLING) && frame && !hit && (y_next >= Y_LIMIT);
    assign drawable = (state == SLOT_FALLING) || ((state == SLOT_HIT) && hit_cnt[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SLOT_FREE;
            x       <= '0;
            y       <= '0;
            hit_cnt <= '0;
        end else begin
            case (state)
                SLOT_FREE: begin
                    if (spawn) begin
                        state <= SLOT_FALLING;
                        x     <= spawn_x;
                        y     <= '0;
                    end
                end
                SLOT_FALLING: begin
                    if (hit) begin
                        state   <= SLOT_HIT;
                        hit_cnt <= 4'(HIT_FRAMES);
                    end else if (frame) begin
                        if (y_next >= Y_LIMIT) state <= SLOT_FREE;
                        else                   y     <= y_next[10:0];
                    end
                end
                SLOT_HIT: begin
                    if (frame) begin
                        hit_cnt <= cnt_dec;
                        if (cnt_dec == 4'd0) state <= SLOT_FREE;
                    end
                end
                default: state <= SLOT_FREE;
            endcase
        end
    end

endmodule

// File: rtl/syringe_controller.sv
// Periodic spawner over a pool of syringe slots plus a registered per-pixel sprite selector.
// Pixel outputs lag pixelX/pixelY by one clock; lowest-index drawable slot wins overlaps.
module syringe_controller
    import syringe_pkg::*;
#(
    parameter int NUM_SLOTS    = NUM_SLOTS_DEF,
    parameter int SPAWN_PERIOD = SPAWN_PERIOD_DEF,
    parameter int FALL_SPEED   = FALL_SPEED_DEF,
    parameter int OBJ_SIZE     = OBJ_SIZE_DEF,
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int HIT_FRAMES   = HIT_FRAMES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic [10:0]          spawnX,
    input  logic [NUM_SLOTS-1:0] hitSlot,
    output logic [10:0]          offsetX,
    output logic [10:0]          offsetY,
    output logic                 insideRectangle,
    output logic [1:0]           activeSlot,
    output logic [NUM_SLOTS-1:0] slotBusy,
    output logic                 missedPulse,
    output logic                 spawnDropped
);

    localparam int          FC_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - OBJ_SIZE);

    logic [FC_W-1:0]      frame_cnt;
    logic                 spawn_try;
    logic [10:0]          spawn_x_c;
    logic [NUM_SLOTS-1:0] spawn_vec;
    logic                 any_free;

    logic [10:0]          slot_x  [NUM_SLOTS];
    logic [10:0]          slot_y  [NUM_SLOTS];
    slot_state_t          slot_st [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_draw;
    logic [NUM_SLOTS-1:0] slot_leave;

    logic                 sel_hit;
    logic [1:0]           sel_idx;
    logic [10:0]          sel_ox;
    logic [10:0]          sel_oy;

    assign spawn_try = startOfFrame && (frame_cnt == FC_W'(SPAWN_PERIOD - 1));
    assign spawn_x_c = (spawnX > X_MAX) ? X_MAX : spawnX;

    always_ff @(posedge clk) begin
        if (reset)             frame_cnt <= '0;
        else if (startOfFrame) frame_cnt <= spawn_try ? '0 : frame_cnt + FC_W'(1);
    end

    // Allocation looks at the pre-update states, so a slot freed this cycle is not reused until the next attempt.
    always_comb begin
        spawn_vec = '0;
        any_free  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!any_free && slot_st[i] == SLOT_FREE) begin
                any_free     = 1'b1;
                spawn_vec[i] = spawn_try & enable;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        syringe_slot #(
            .OBJ_SIZE  (OBJ_SIZE),
            .SCREEN_H  (SCREEN_H),
            .FALL_SPEED(FALL_SPEED),
            .HIT_FRAMES(HIT_FRAMES)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .frame   (startOfFrame),
            .spawn   (spawn_vec[g]),
            .spawn_x (spawn_x_c),
            .hit     (hitSlot[g]),
            .x       (slot_x[g]),
            .y       (slot_y[g]),
            .state   (slot_st[g]),
            .drawable(slot_draw[g]),
            .leaving (slot_leave[g])
        );
        assign slotBusy[g] = (slot_st[g] != SLOT_FREE);
    end

    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_ox  = '0;
        sel_oy  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!sel_hit && slot_draw[i] &&
                in_span(pixelX, slot_x[i], OBJ_SIZE) && in_span(pixelY, slot_y[i], OBJ_SIZE)) begin
                sel_hit = 1'b1;
                sel_idx = 2'(i);
                sel_ox  = pixelX - slot_x[i];
                sel_oy  = pixelY - slot_y[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            offsetX         <= '0;
            offsetY         <= '0;
            insideRectangle <= 1'b0;
            activeSlot      <= '0;
            missedPulse     <= 1'b0;
            spawnDropped    <= 1'b0;
        end else begin
            offsetX         <= sel_ox;
            offsetY         <= sel_oy;
            insideRectangle <= sel_hit;
            activeSlot      <= sel_idx;
            missedPulse     <= |slot_leave;
            spawnDropped    <= spawn_try && enable && !any_free;
        end
    end

endmodule

// File: tb/tb_syringe_controller.sv
// Directed bench: a frame-level model checked every cycle on the default DUT, plus literal checks on a fast-spawn DUT.
module tb_syringe_controller;

    localparam int OBJ = 32, SW = 640, SH = 480, SPD = 2, HITF = 8, PERIOD = 120;
    localparam int S_FREE = 0, S_FALL = 1, S_HIT = 2;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, enable;
    logic [10:0] pixelX, pixelY, spawnX;
    logic [3:0]  hitSlot;
    logic [10:0] offsetX, offsetY;
    logic        insideRectangle, missedPulse, spawnDropped;
    logic [1:0]  activeSlot;
    logic [3:0]  slotBusy;

    logic        b_reset, b_sof, b_en;
    logic [10:0] b_px, b_py, b_spx;
    logic [3:0]  b_hit;
    logic [10:0] b_ox, b_oy;
    logic        b_in, b_miss, b_drop;
    logic [1:0]  b_as;
    logic [3:0]  b_busy;

    int n_assert = 0, n_fail = 0;
    bit chk_on = 0;

    int mx[4], my[4], ms[4], mc[4], fc;
    int e_ox, e_oy, e_in, e_as, e_busy, e_miss, e_drop;
    int n_ox, n_oy, n_in, n_as, n_busy, n_miss, n_drop;

    always #5 clk = ~clk;

    syringe_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
        .pixelX(pixelX), .pixelY(pixelY), .spawnX(spawnX), .hitSlot(hitSlot),
        .offsetX(offsetX), .offsetY(offsetY), .insideRectangle(insideRectangle),
        .activeSlot(activeSlot), .slotBusy(slotBusy), .missedPulse(missedPulse),
        .spawnDropped(spawnDropped)
    );

    syringe_controller #(.SPAWN_PERIOD(1)) dut_b (
        .clk(clk), .reset(b_reset), .startOfFrame(b_sof), .enable(b_en),
        .pixelX(b_px), .pixelY(b_py), .spawnX(b_spx), .hitSlot(b_hit),
        .offsetX(b_ox), .offsetY(b_oy), .insideRectangle(b_in),
        .activeSlot(b_as), .slotBusy(b_busy), .missedPulse(b_miss),
        .spawnDropped(b_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level behaviour: what the outputs must be after the coming clock edge.
    task automatic model_step();
        int  nfree, ny, px, py;
        bit  found, spawn;
        px = pixelX; py = pixelY;
        n_ox = 0; n_oy = 0; n_in = 0; n_as = 0; n_busy = 0; n_miss = 0; n_drop = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin mx[i] = 0; my[i] = 0; ms[i] = S_FREE; mc[i] = 0; end
            fc = 0;
            return;
        end
        found = 0;
        for (int i = 0; i < 4; i++) begin
            if (!found && (ms[i] == S_FALL || (ms[i] == S_HIT && mc[i] % 2 == 1)) &&
                px >= mx[i] && px < mx[i] + OBJ && py >= my[i] && py < my[i] + OBJ) begin
                found = 1; n_in = 1; n_as = i; n_ox = px - mx[i]; n_oy = py - my[i];
            end
        end
        spawn = startOfFrame && fc == PERIOD - 1;
        if (startOfFrame) fc = spawn ? 0 : fc + 1;
        nfree = -1;
        for (int i = 0; i < 4; i++) if (nfree < 0 && ms[i] == S_FREE) nfree = i;
        for (int i = 0; i < 4; i++) begin
            if (hitSlot[i] && ms[i] == S_FALL) begin
                ms[i] = S_HIT; mc[i] = HITF;
            end else if (startOfFrame && ms[i] == S_FALL) begin
                ny = my[i] + SPD;
                if (ny + OBJ >= SH) begin ms[i] = S_FREE; n_miss = 1; end
                else my[i] = ny;
            end else if (startOfFrame && ms[i] == S_HIT) begin
                mc[i]--;
                if (mc[i] == 0) ms[i] = S_FREE;
            end
        end
        if (spawn && enable) begin
            if (nfree >= 0) begin
                mx[nfree] = (spawnX > SW - OBJ) ? SW - OBJ : int'(spawnX);
                my[nfree] = 0; ms[nfree] = S_FALL;
            end else n_drop = 1;
        end
        for (int i = 0; i < 4; i++) if (ms[i] != S_FREE) n_busy |= (1 << i);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        e_ox = n_ox; e_oy = n_oy; e_in = n_in; e_as = n_as;
        e_busy = n_busy; e_miss = n_miss; e_drop = n_drop;
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1; tick();
            startOfFrame = 0; hitSlot = 0; tick();
        end
    endtask

    task automatic probe(input int px, input int py);
        pixelX = 11'(px); pixelY = 11'(py); tick();
    endtask

    task automatic btick();
        @(posedge clk); #1;
    endtask

    task automatic bframes(input int n);
        for (int i = 0; i < n; i++) begin
            b_sof = 1; btick(); b_sof = 0; btick();
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("offsetX", offsetX, e_ox);
            check("offsetY", offsetY, e_oy);
            check("insideRectangle", insideRectangle, e_in);
            check("activeSlot", activeSlot, e_as);
            check("slotBusy", slotBusy, e_busy);
            check("missedPulse", missedPulse, e_miss);
            check("spawnDropped", spawnDropped, e_drop);
        end
    end

    initial begin
        reset = 1; startOfFrame = 1; enable = 1; hitSlot = 4'hf;
        pixelX = 0; pixelY = 0; spawnX = 100;
        b_reset = 1; b_sof = 0; b_en = 0; b_px = 0; b_py = 0; b_spx = 0; b_hit = 0;
        tick(); tick();
        chk_on = 1;
        check("rst_busy", slotBusy, 0);
        check("rst_inside", insideRectangle, 0);
        check("rst_missed", missedPulse, 0);
        check("rst_dropped", spawnDropped, 0);
        reset = 0; startOfFrame = 0; hitSlot = 0;

        frames(119);
        check("no_spawn_yet", slotBusy, 4'b0000);
        frames(1);
        check("spawn0_busy", slotBusy, 4'b0001);
        probe(100, 0);
        check("s0_corner_in", insideRectangle, 1);
        check("s0_corner_ox", offsetX, 0);
        probe(131, 31);
        check("s0_far_ox", offsetX, 31);
        check("s0_far_oy", offsetY, 31);
        probe(132, 0);
        check("s0_right_out", insideRectangle, 0);
        check("s0_right_ox", offsetX, 0);

        spawnX = 700;
        frames(120);
        probe(608, 0);
        check("clamp_slot", activeSlot, 1);
        check("clamp_ox", offsetX, 0);
        probe(639, 31);
        check("clamp_edge_ox", offsetX, 31);

        frames(103);
        probe(100, 446);
        check("s0_y446_in", insideRectangle, 1);
        check("s0_y446_oy", offsetY, 0);
        startOfFrame = 1; tick();
        check("leave_missed", missedPulse, 1);
        check("leave_busy", slotBusy, 4'b0010);
        startOfFrame = 0; tick();
        check("leave_missed_end", missedPulse, 0);

        spawnX = 200;
        frames(16);
        check("respawn_busy", slotBusy, 4'b0011);
        startOfFrame = 1; hitSlot = 4'b1110; tick();
        check("hit_busy", slotBusy, 4'b0011);
        startOfFrame = 0; hitSlot = 0;
        probe(608, 240);
        check("hit_cnt8_hidden", insideRectangle, 0);
        for (int k = 1; k <= 8; k++) begin
            startOfFrame = 1; tick();
            startOfFrame = 0;
            probe(608, 240);
            check("hit_blink", insideRectangle, (k < 8 && (8 - k) % 2 == 1) ? 1 : 0);
            check("hit_busy1", slotBusy[1], (k < 8) ? 1 : 0);
        end

        frames(110);
        enable = 0;
        startOfFrame = 1; tick();
        check("disabled_busy", slotBusy, 4'b0001);
        check("disabled_drop", spawnDropped, 0);
        startOfFrame = 0; tick();
        enable = 1;

        startOfFrame = 1; hitSlot = 4'b0001; tick();
        hitSlot = 0; tick();
        startOfFrame = 0; pixelX = 205; pixelY = 245; tick();
        check("pre_rst_blink", insideRectangle, 1);
        reset = 1; startOfFrame = 1; hitSlot = 4'b0001; tick();
        check("rst_hit_busy", slotBusy, 0);
        check("rst_hit_inside", insideRectangle, 0);
        check("rst_hit_oy", offsetY, 0);
        reset = 0; startOfFrame = 0; hitSlot = 0;
        frames(119);
        check("rst_fc_none", slotBusy, 0);
        frames(1);
        check("rst_fc_spawn", slotBusy, 4'b0001);

        btick(); b_reset = 0; b_en = 1;
        b_spx = 200; bframes(1);
        b_spx = 500; bframes(1);
        b_spx = 200; bframes(1);
        b_spx = 300; bframes(1);
        check("b_full", b_busy, 4'b1111);
        b_sof = 1; btick();
        check("b_drop_hi", b_drop, 1);
        check("b_drop_busy", b_busy, 4'b1111);
        b_sof = 0; btick();
        check("b_drop_lo", b_drop, 0);
        bframes(96);
        b_px = 210; b_py = 205; btick();
        check("ovl_slot", b_as, 0);
        check("ovl_ox", b_ox, 10);
        check("ovl_oy", b_oy, 5);
        check("ovl_in", b_in, 1);
        b_py = 198; btick();
        check("ovl2_slot", b_as, 2);
        check("ovl2_oy", b_oy, 2);

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
